// File: rtl/fir_mac_engine.sv
// Single-MAC FIR engine: computes one output y[n] = sum h[k]*x[n-k] per request,
// streaming taps from external coefficient/sample RAMs and writing one rounded, saturated result.
module fir_mac_engine #(
   parameter int DATA_W = 16,
   parameter int COEF_W = 16
) (
   input  logic                     clk_b,
   input  logic                     rst,
   input  logic                     mac_start,
   input  logic [12:0]              A_probki_FIR,
   input  logic [8:0]               ile_wsp,
   input  logic [13:0]              ile_probek,
   output logic [7:0]               A_wsp,
   input  logic signed [COEF_W-1:0] D_wsp,
   output logic [12:0]              A_x,
   input  logic signed [DATA_W-1:0] D_x,
   output logic [12:0]              A_y,
   output logic signed [15:0]       D_y,
   output logic                     we_y,
   output logic                     mac_busy,
   output logic                     mac_done,
   output logic                     y_sat
);

   localparam int ACC_W  = 40;
   localparam int PROD_W = DATA_W + COEF_W;
   localparam logic signed [ACC_W-1:0] RND  = 40'sd16384;
   localparam logic signed [ACC_W-1:0] MAXV = 40'sd32767;
   localparam logic signed [ACC_W-1:0] MINV = -40'sd32768;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t                    state;
   logic [12:0]               n_r;
   logic [8:0]                k_len;
   logic [13:0]               n_len;
   logic [8:0]                k_idx;
   logic                      drain_cnt;
   logic                      vld_p0;
   logic                      vld_p1;
   logic signed [ACC_W-1:0]   acc;
   logic signed [PROD_W-1:0]  prod_p1;
   logic [8:0]                k_clamp;

   // Sample index n-k lies inside the stored record [0, N).
   function automatic logic tap_ok(input logic [12:0] n, input logic [8:0] k,
                                   input logic [13:0] nn);
      logic signed [13:0] d;
      d = $signed({1'b0, n}) - $signed({5'b0, k});
      return (d >= 14'sd0) && ({1'b0, d[12:0]} < nn);
   endfunction

   // Returns {saturated, value}: round half up at bit 15, then clip to 16 bits.
   function automatic logic [16:0] round_sat(input logic signed [ACC_W-1:0] a);
      logic signed [ACC_W-1:0] r;
      r = (a + RND) >>> 15;
      if (r > MAXV)
         return {1'b1, 16'h7FFF};
      else if (r < MINV)
         return {1'b1, 16'h8000};
      else
         return {1'b0, r[15:0]};
   endfunction

   assign k_clamp = (ile_wsp > 9'd256) ? 9'd256 : ile_wsp;
   assign prod_p1 = D_wsp * D_x;

   always_ff @(posedge clk_b) begin
      if (rst) begin
         state     <= IDLE;
         k_idx     <= '0;
         drain_cnt <= 1'b0;
         vld_p0    <= 1'b0;
         vld_p1    <= 1'b0;
         acc       <= '0;
         A_wsp     <= '0;
         A_x       <= '0;
         A_y       <= '0;
         D_y       <= '0;
         we_y      <= 1'b0;
         mac_busy  <= 1'b0;
         mac_done  <= 1'b0;
         y_sat     <= 1'b0;
      end else begin
         we_y     <= 1'b0;
         mac_done <= 1'b0;
         vld_p0   <= 1'b0;
         // p1: RAM data for the tap issued two edges ago is on D_wsp/D_x now
         vld_p1   <= vld_p0;
         if (vld_p1)
            acc <= acc + ACC_W'(prod_p1);
         case (state)
            IDLE: begin
               if (mac_start) begin
                  n_r       <= A_probki_FIR;
                  k_len     <= k_clamp;
                  n_len     <= ile_probek;
                  acc       <= '0;
                  drain_cnt <= 1'b0;
                  mac_busy  <= 1'b1;
                  if (k_clamp != 9'd0) begin
                     A_wsp  <= 8'd0;
                     A_x    <= A_probki_FIR;
                     vld_p0 <= tap_ok(A_probki_FIR, 9'd0, ile_probek);
                     k_idx  <= 9'd1;
                     state  <= RUN;
                  end else begin
                     state <= DRAIN;
                  end
               end
            end
            RUN: begin
               if (k_idx == k_len) begin
                  state <= DRAIN;
               end else begin
                  A_wsp  <= k_idx[7:0];
                  A_x    <= n_r - 13'(k_idx);
                  vld_p0 <= tap_ok(n_r, k_idx, n_len);
                  k_idx  <= k_idx + 9'd1;
               end
            end
            DRAIN: begin
               if (drain_cnt) begin
                  {y_sat, D_y} <= round_sat(acc);
                  A_y      <= n_r;
                  we_y     <= 1'b1;
                  mac_done <= 1'b1;
                  mac_busy <= 1'b0;
                  state    <= IDLE;
               end else begin
                  drain_cnt <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/fir_mac_engine.md
FIR_MAC_ENGINE -- requirements
Module: fir_mac_engine

Interface
REQ-001 SHALL have port clk_b  in  1  single clock; all logic on rising edge.
REQ-002 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have port mac_start  in  1  one-cycle request to compute y[n].
REQ-004 SHALL have port A_probki_FIR  in  13  output index n from the sample counter.
REQ-005 SHALL have port ile_wsp  in  9  tap count K, 0..256.
REQ-006 SHALL have port ile_probek  in  14  valid input sample count N.
REQ-007 SHALL have port A_wsp  out  8  coefficient RAM read address.
REQ-008 SHALL have port D_wsp  in  16  signed coefficient, valid one cycle after A_wsp.
REQ-009 SHALL have port A_x  out  13  sample RAM read address.
REQ-010 SHALL have port D_x  in  16  signed sample, valid one cycle after A_x.
REQ-011 SHALL have ports A_y (out, 13), D_y (out, 16), we_y (out, 1): result RAM write address, data and strobe.
REQ-012 SHALL have ports mac_busy (out, 1), mac_done (out, 1), y_sat (out, 1): engine busy, one-cycle completion pulse, saturation flag.

Function
REQ-013 SHALL compute y[n] = sum over k=0..K-1 of h[k]*x[n-k], with x[i]=0 for i<0 or i>=N.
REQ-014 SHALL use states IDLE, RUN, DRAIN; mac_busy=1 in RUN and DRAIN only.
REQ-015 SHALL accept mac_start only in IDLE; at accepting edge E0 latch n, K, N, clear accumulator, k=0, go RUN (K>=1) or DRAIN (K=0).
REQ-016 SHALL ignore mac_start in RUN/DRAIN; no queuing.
REQ-017 SHALL drive registered A_wsp=k, A_x=(n-k) mod 2^13 during RUN, k incrementing each cycle, for K cycles; leave RUN to DRAIN after tap K-1 issued.
REQ-018 SHALL pipeline a tap-valid bit (0<=n-k<N, computed in 14-bit signed) with each address; invalid taps add 0 regardless of D_x.
REQ-019 SHALL accumulate tap k (signed 16x16 -> 32-bit product, sign-extended) into a 40-bit signed accumulator at edge E(k+2).
REQ-020 SHALL, at edge E(K+2) (E2 for K=0), register D_y = clip((acc + 2^14) >>> 15) to [-32768, 32767], A_y=n, we_y=1, mac_done=1, y_sat=1 iff clipping occurred, and return to IDLE.
REQ-021 SHALL hold we_y, mac_done high exactly one cycle; y_sat, D_y, A_y hold until next completion.
REQ-022 SHALL accept a mac_start presented in the mac_done cycle (state is IDLE).
REQ-023 SHALL, for K=0, produce D_y=0, y_sat=0, no RAM reads.
REQ-024 SHALL treat K>256 as 256.

Reset
REQ-025 SHALL, while rst=1 at a clock edge, force IDLE, accumulator 0 and all outputs 0 (A_wsp, A_x, A_y, D_y, we_y, mac_busy, mac_done, y_sat).
REQ-026 SHALL abort an in-progress computation on rst with no we_y pulse; rst has priority over mac_start.

Verification
REQ-027 K=1, N=10, n=5, h0=0x4000, x[5]=0x2000 -> mac_done after E3, D_y=0x1000, A_y=5, y_sat=0.
REQ-028 K=3, n=0, h=[0x4000,0x7FFF,0x7FFF], x[0]=0x4000, RAM returning 0x7FFF at other addresses -> D_y=0x2000 (taps 1,2 zero-padded).
REQ-029 K=4, N=10, n=3, all h and x = 0x7FFF -> D_y=0x7FFF, y_sat=1; with x=0x8000 -> D_y=0x8000, y_sat=1.
REQ-030 K=3, N=10, n=11, h=0x4000, x[9]=0x4000, x[10]=x[11]=0x7FFF -> D_y=0x2000 (only tap 2 valid), A_y=11.
REQ-031 mac_start pulsed again at E1 of a K=4 run -> single mac_done after E6; rst at E3 of another run -> mac_busy=0 next cycle, no we_y.
REQ-032 mac_start in mac_done cycle with K=2 -> accepted, second mac_done exactly 4 edges later.
